// File: rtl/clock_divider_gate.sv
`default_nettype none
// ============================================================================
// Module   : clock_divider_gate
// Brief    : Even-ratio clock divider with glitch-free run/stop gating.
// Revision : 1.0 - initial release
// ============================================================================
module clock_divider_gate #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk_in,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] div_ratio,
    input  logic                 div_load,
    output logic                 clk_out,
    output logic                 running,
    output logic                 div_ack,
    output logic [DIV_WIDTH-1:0] div_active
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    localparam logic [DIV_WIDTH-1:0] c_CNT_ZERO = '0;
    localparam logic [DIV_WIDTH-1:0] c_CNT_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]           r_state;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_div_pend;
    logic                 r_pend;
    logic                 r_clk_out;
    logic                 r_running;
    logic                 r_div_ack;
    logic [DIV_WIDTH-1:0] r_div_active;
    logic                 w_terminal;

    assign w_terminal = (r_cnt == r_div_active);

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_IDLE;
            r_cnt        <= c_CNT_ZERO;
            r_div_pend   <= c_CNT_ZERO;
            r_pend       <= 1'b0;
            r_clk_out    <= 1'b0;
            r_running    <= 1'b0;
            r_div_ack    <= 1'b0;
            r_div_active <= c_CNT_ZERO;
        end else begin
            r_div_ack <= 1'b0;
            if (div_load) begin
                r_div_pend <= div_ratio;
                r_pend     <= 1'b1;
            end

            if (r_state == c_IDLE) begin
                r_clk_out <= 1'b0;
                r_cnt     <= c_CNT_ZERO;
                // A strobe arriving in the same cycle stays pending for the next edge.
                if (r_pend) begin
                    r_div_active <= r_div_pend;
                    r_div_ack    <= 1'b1;
                    if (!div_load) begin
                        r_pend <= 1'b0;
                    end
                end
                if (enable) begin
                    r_state   <= c_RUN;
                    r_clk_out <= 1'b1;
                    r_running <= 1'b1;
                end
            end else if (!w_terminal) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end else if (r_clk_out) begin
                // High->low boundary: a fresh strobe beats any older pending ratio.
                r_clk_out <= 1'b0;
                r_cnt     <= c_CNT_ZERO;
                if (div_load) begin
                    r_div_active <= div_ratio;
                    r_pend       <= 1'b0;
                    r_div_ack    <= 1'b1;
                end else if (r_pend) begin
                    r_div_active <= r_div_pend;
                    r_pend       <= 1'b0;
                    r_div_ack    <= 1'b1;
                end
            end else begin
                // Low->high boundary is the only place a stop is honoured.
                r_cnt <= c_CNT_ZERO;
                if (enable) begin
                    r_clk_out <= 1'b1;
                end else begin
                    r_state   <= c_IDLE;
                    r_running <= 1'b0;
                end
            end
        end
    end

    assign clk_out    = r_clk_out;
    assign running    = r_running;
    assign div_ack    = r_div_ack;
    assign div_active = r_div_active;

endmodule
`default_nettype wire

// File: tb/tb_clock_divider_gate.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_divider_gate
// Brief    : Self-checking bench for clock_divider_gate against a phase model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_divider_gate;

    localparam int W = 8;

    logic         clk_in    = 1'b0;
    logic         reset_n   = 1'b0;
    logic         enable    = 1'b0;
    logic         div_load  = 1'b0;
    logic [W-1:0] div_ratio = '0;
    logic         clk_out;
    logic         running;
    logic         div_ack;
    logic [W-1:0] div_active;

    int n_chk  = 0;
    int n_fail = 0;

    // Phase-level reference: which level we are in and how many cycles of it remain.
    bit           m_run;
    bit           m_level;
    int           m_left;
    logic [W-1:0] m_div;
    bit           m_pend;
    logic [W-1:0] m_pendv;
    bit           m_ack;

    clock_divider_gate #(.DIV_WIDTH(W)) dut (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .enable     (enable),
        .div_ratio  (div_ratio),
        .div_load   (div_load),
        .clk_out    (clk_out),
        .running    (running),
        .div_ack    (div_ack),
        .div_active (div_active)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [W+2:0] dut_vec();
        return {clk_out, running, div_ack, div_active};
    endfunction

    function automatic logic [W+2:0] mdl_vec();
        return {m_run & m_level, m_run, m_ack, m_div};
    endfunction

    task automatic model_reset();
        m_run = 0; m_level = 0; m_left = 0; m_div = '0;
        m_pend = 0; m_pendv = '0; m_ack = 0;
    endtask

    task automatic model_edge();
        m_ack = 0;
        if (!m_run) begin
            if (m_pend) begin
                m_div = m_pendv; m_pend = 0; m_ack = 1;
            end
            if (div_load) begin
                m_pend = 1; m_pendv = div_ratio;
            end
            if (enable) begin
                m_run = 1; m_level = 1; m_left = int'(m_div) + 1;
            end
        end else if (m_left > 1) begin
            m_left--;
            if (div_load) begin
                m_pend = 1; m_pendv = div_ratio;
            end
        end else if (m_level) begin
            m_level = 0;
            if (div_load) begin
                m_div = div_ratio; m_pend = 0; m_ack = 1;
            end else if (m_pend) begin
                m_div = m_pendv; m_pend = 0; m_ack = 1;
            end
            m_left = int'(m_div) + 1;
        end else begin
            if (div_load) begin
                m_pend = 1; m_pendv = div_ratio;
            end
            if (enable) begin
                m_level = 1; m_left = int'(m_div) + 1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; enable = 1'b0; div_load = 1'b0; div_ratio = '0;
        model_reset();
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        reset_n = 1'b1;
        @(posedge clk_in);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL reset_clk_out act=%b exp=0", clk_out); end
        n_chk++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running act=%b exp=0", running); end
        n_chk++; if (div_ack !== 1'b0) begin n_fail++; $display("FAIL reset_div_ack act=%b exp=0", div_ack); end
        n_chk++; if (div_active !== '0) begin n_fail++; $display("FAIL reset_div_active act=%0d exp=0", div_active); end
    endtask

    task automatic test_div2();
        enable = 1'b1;
        tick();
        n_chk++; if (clk_out !== 1'b1 || running !== 1'b1) begin
            n_fail++; $display("FAIL div2_start act=%b%b exp=11", clk_out, running);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_chk++; if (clk_out !== ((i % 2) == 1)) begin
                n_fail++; $display("FAIL div2_toggle i=%0d act=%b exp=%b", i, clk_out, (i % 2) == 1);
            end
            n_chk++; if (dut_vec() !== mdl_vec()) begin
                n_fail++; $display("FAIL div2_model act=%h exp=%h", dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic go_idle();
        int n;
        enable = 1'b0;
        n = 0;
        while (m_run && n < 2000) begin
            tick(); n++;
            n_chk++; if (dut_vec() !== mdl_vec()) begin
                n_fail++; $display("FAIL stop_model act=%h exp=%h", dut_vec(), mdl_vec());
            end
        end
        n_chk++; if (running !== 1'b0) begin n_fail++; $display("FAIL stop_timeout running act=%b exp=0", running); end
    endtask

    task automatic test_load_idle();
        int hi;
        go_idle();
        div_load = 1'b1; div_ratio = 8'd3;
        tick();
        div_load = 1'b0;
        n_chk++; if (div_ack !== 1'b0) begin n_fail++; $display("FAIL idle_ack_early act=%b exp=0", div_ack); end
        tick();
        n_chk++; if (div_ack !== 1'b1 || div_active !== 8'd3) begin
            n_fail++; $display("FAIL idle_load act=%b/%0d exp=1/3", div_ack, div_active);
        end
        enable = 1'b1;
        hi = 0;
        for (int i = 0; i < 44; i++) begin
            tick();
            if (i < 8) hi += int'(clk_out);
            n_chk++; if (dut_vec() !== mdl_vec()) begin
                n_fail++; $display("FAIL div4_model act=%h exp=%h", dut_vec(), mdl_vec());
            end
        end
        n_chk++; if (hi !== 4) begin n_fail++; $display("FAIL div4_high_cycles act=%0d exp=4", hi); end
    endtask

    task automatic wait_high_start(input string tag);
        int n;
        n = 0;
        while (!(m_run && m_level && m_left == int'(m_div) + 1) && n < 2000) begin
            tick(); n++;
            n_chk++; if (dut_vec() !== mdl_vec()) begin
                n_fail++; $display("FAIL %s_wait_model act=%h exp=%h", tag, dut_vec(), mdl_vec());
            end
        end
        n_chk++; if (clk_out !== 1'b1) begin n_fail++; $display("FAIL %s_wait act=%b exp=1", tag, clk_out); end
    endtask

    task automatic test_reload_run();
        logic [15:0] seq;
        wait_high_start("reload");
        tick();
        div_load = 1'b1; div_ratio = 8'd1;
        tick();
        div_load = 1'b0;
        // Now in 3rd high cycle: expect H,L,L,H,H,L,L,H,H,L,L,H,H,L,L,H
        for (int i = 0; i < 16; i++) begin
            tick();
            seq[15-i] = clk_out;
            if (i == 1) begin
                n_chk++; if (div_ack !== 1'b1 || div_active !== 8'd1) begin
                    n_fail++; $display("FAIL reload_ack act=%b/%0d exp=1/1", div_ack, div_active);
                end
            end
            n_chk++; if (dut_vec() !== mdl_vec()) begin
                n_fail++; $display("FAIL reload_model act=%h exp=%h", dut_vec(), mdl_vec());
            end
        end
        n_chk++; if (seq !== 16'b1001_1001_1001_1001) begin
            n_fail++; $display("FAIL reload_pattern act=%b exp=1001100110011001", seq);
        end
    endtask

    task automatic test_stop_restart();
        int hi, lo;
        go_idle();
        div_load = 1'b1; div_ratio = 8'd3;
        tick();
        div_load = 1'b0; enable = 1'b1;
        wait_high_start("stop");
        enable = 1'b0;
        hi = 1; lo = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (clk_out) hi++;
            else if (running) lo++;
            n_chk++; if (dut_vec() !== mdl_vec()) begin
                n_fail++; $display("FAIL stop_model act=%h exp=%h", dut_vec(), mdl_vec());
            end
        end
        n_chk++; if (hi !== 4 || lo !== 4 || running !== 1'b0) begin
            n_fail++; $display("FAIL stop_phases act=%0d/%0d/%b exp=4/4/0", hi, lo, running);
        end
        enable = 1'b1;
        tick();
        n_chk++; if (clk_out !== 1'b1) begin n_fail++; $display("FAIL restart act=%b exp=1", clk_out); end
        for (int i = 0; i < 16; i++) begin
            tick();
            n_chk++; if (dut_vec() !== mdl_vec()) begin
                n_fail++; $display("FAIL restart_model act=%h exp=%h", dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_load_collision();
        int n, acks, lo;
        wait_high_start("coll");
        div_load = 1'b1; div_ratio = 8'd5;
        tick();
        div_load = 1'b0;
        n = 0;
        while (!(m_level && m_left == 1) && n < 100) begin
            tick(); n++;
        end
        div_load = 1'b1; div_ratio = 8'd2;
        tick();
        div_load = 1'b0;
        n_chk++; if (div_active !== 8'd2 || div_ack !== 1'b1 || clk_out !== 1'b0) begin
            n_fail++; $display("FAIL coll_apply act=%0d/%b/%b exp=2/1/0", div_active, div_ack, clk_out);
        end
        acks = 0; lo = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            acks += int'(div_ack);
            if (i < 4 && !clk_out) lo++;
            n_chk++; if (dut_vec() !== mdl_vec()) begin
                n_fail++; $display("FAIL coll_model act=%h exp=%h", dut_vec(), mdl_vec());
            end
        end
        n_chk++; if (acks !== 0 || lo !== 3) begin
            n_fail++; $display("FAIL coll_phase acks=%0d low=%0d exp=0/3", acks, lo);
        end
    endtask

    task automatic test_async_reset();
        wait_high_start("areset");
        tick();
        reset_n = 1'b0;
        model_reset();
        #2;
        n_chk++; if (dut_vec() !== '0) begin
            n_fail++; $display("FAIL async_reset act=%h exp=0", dut_vec());
        end
        @(negedge clk_in);
        reset_n = 1'b1; enable = 1'b1;
        tick();
        n_chk++; if (clk_out !== 1'b1 || running !== 1'b1 || div_active !== '0) begin
            n_fail++; $display("FAIL reset_restart act=%b%b/%0d exp=11/0", clk_out, running, div_active);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_chk++; if (dut_vec() !== mdl_vec()) begin
                n_fail++; $display("FAIL reset_restart_model act=%h exp=%h", dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_max_ratio();
        go_idle();
        div_load = 1'b1; div_ratio = 8'hFF;
        tick();
        div_load = 1'b0; enable = 1'b1;
        for (int i = 0; i < 1100; i++) begin
            tick();
            n_chk++; if (dut_vec() !== mdl_vec()) begin
                n_fail++; $display("FAIL max_model act=%h exp=%h", dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            enable   = ($urandom_range(0, 9) < 8);
            div_load = ($urandom_range(0, 7) == 0);
            div_ratio = ($urandom_range(0, 15) == 0) ? W'($urandom_range(0, 40))
                                                     : W'($urandom_range(0, 4));
            tick();
            n_chk++; if (dut_vec() !== mdl_vec()) begin
                n_fail++; $display("FAIL random_model i=%0d act=%h exp=%h", i, dut_vec(), mdl_vec());
            end
        end
        div_load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_div2();
        test_load_idle();
        test_reload_run();
        test_stop_restart();
        test_load_collision();
        test_async_reset();
        test_max_ratio();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clock_divider_gate.md
Name: clock_divider_gate

Overview:
Programmable clock source stage that drives the clk_in of the clock distribution tree. Divides the incoming reference clock by an even ratio and gates the result on and off. clk_out is a registered flop output, so it never glitches. Ratio changes and stop requests take effect only at phase boundaries, so no runt pulse ever enters the tree.

Parameters:
DIV_WIDTH, 8, width of the half-period divide value; half-period = div value + 1 reference cycles.

Ports:
clk_in  input  1  reference clock; all logic on its rising edge
reset_n  input  1  asynchronous active-low reset
enable  input  1  run request, level-sensitive, same clock domain
div_ratio  input  DIV_WIDTH  requested half-period minus 1
div_load  input  1  1-cycle strobe that captures div_ratio
clk_out  output  1  divided/gated clock to the tree root; registered
running  output  1  1 while the FSM is in RUN
div_ack  output  1  1-cycle pulse when a captured ratio becomes active
div_active  output  DIV_WIDTH  half-period value currently in force

Behaviour:
- Clock and reset: one clock, clk_in. Reset is asynchronous, active-low, on reset_n.
- Reset (asynchronous, immediate, no clock needed):
  - state=IDLE, clk_out=0, running=0, div_ack=0, div_active=0.
  - Internal cnt=0, pend=0, div_pend=0.
  - A high pulse truncated by reset is accepted; reset overrides glitch-freedom.
- Registers:
  - cnt, DIV_WIDTH bits; never exceeds div_active, so no overflow.
  - div_pend, DIV_WIDTH bits, with valid flag pend.
- div_load:
  - Captures div_ratio into div_pend and sets pend.
  - A later load before application overwrites it; last load wins.
- FSM states: IDLE and RUN.
- IDLE:
  - clk_out=0, cnt held 0.
  - If pend: div_active<=div_pend, pend<=0, div_ack pulses. A div_load in IDLE is therefore active 2 cycles after the strobe.
  - If enable sampled 1: next edge state<=RUN, clk_out<=1, cnt<=0. The first high phase starts 1 cycle after enable is sampled.
  - A ratio and enable arriving together: the pending ratio is applied in the same edge as the RUN entry.
- RUN, cnt != div_active: cnt<=cnt+1, clk_out holds.
- RUN, terminal count (cnt==div_active) with clk_out=1 (high->low boundary):
  - clk_out<=0, cnt<=0.
  - If div_load is asserted this cycle: div_active<=div_ratio directly, pend<=0. The new strobe wins over any older pending value.
  - Else if pend: div_active<=div_pend, pend<=0.
  - div_ack pulses in the cycle after any application.
  - The new value governs the low phase that starts here.
- RUN, terminal count with clk_out=0 (low->high boundary):
  - If enable=1: clk_out<=1, cnt<=0.
  - If enable=0: state<=IDLE, clk_out stays 0, running<=0.
  - The stop decision is taken only here, so both the last high and last low phases are full width.
- enable dropping or toggling within a phase has no effect until the next low->high boundary.
- Output timing:
  - Steady RUN: high and low phases are each div_active+1 cycles; period = 2*(div_active+1).
  - div_active=0 gives divide-by-2.
  - div_active=2^DIV_WIDTH-1 gives half-period 256 at the default width.
- Output registering: running is registered and equals (state==RUN). div_ack is registered and never high for 2 consecutive cycles unless two applications occur back to back.
- No combinational path from any input to clk_out.

Test Plan:
1. Reset; enable=1 with div_active=0 → clk_out rises 1 cycle after enable is sampled, then toggles every cycle (period 2); running=1 from the same edge.
2. div_load with div_ratio=3 in IDLE → div_ack pulse and div_active=3 two cycles after the strobe. Then enable → clk_out 4 cycles high / 4 low, repeated for at least 5 periods.
3. Running at div 3; div_load div_ratio=1 in the 2nd cycle of a high phase → that high phase stays 4 cycles. Next low phase is 2 cycles, then 2/2. div_ack fires the cycle after the falling edge.
4. Running at div 3; enable drops in the 1st high cycle → high phase completes (4), low phase completes (4), clk_out stays 0, running=0. Re-enable → clk_out high 1 cycle after enable is sampled, full 4-cycle phases.
5. Pending div 5 plus a new div_load of 2 exactly on the high->low terminal cycle → div_active=2 (not 5), low phase 3 cycles, single div_ack pulse.
6. reset_n low mid-high-phase with no clk_in edges → clk_out, running, div_ack, div_active all 0 immediately. After release with enable=1 → restart as in scenario 1.
